// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: N-digit BCD time counter with start/stop/clear, a lap-freeze
// display and a registered digit-scan output for a multiplexed 7-segment driver.
// All timing comes from clock enables derived from clk100MHz; no derived clocks.
module stopwatch_lap_core #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int SCAN_HZ  = 400,
  parameter int N_DIGITS = 4,
  parameter bit WRAP     = 1'b0
) (
  input  logic                  clk100MHz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [3:0]            digit_bcd,
  output logic [N_DIGITS-1:0]   sseg_an,
  output logic                  running,
  output logic                  lap_hold,
  output logic                  ovf
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW       = 4 * N_DIGITS;

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_RESET  = ~N_DIGITS'(1);

  // Reject parameter sets the counters cannot represent.
  generate
    if (TICK_DIV < 1 || SCAN_DIV < 1) begin : g_bad_ratio
      $error("stopwatch_lap_core: CLK_HZ must be >= TICK_HZ and >= SCAN_HZ");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
      $error("stopwatch_lap_core: N_DIGITS must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic r_start_q;
  logic r_stop_q;
  logic r_lap_q;
  logic r_clear_q;
  logic w_start_evt;
  logic w_stop_evt;
  logic w_lap_evt;
  logic w_clear_evt;

  // One-cycle history of each request so only rising edges act.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_lap_q   <= 1'b0;
      r_clear_q <= 1'b0;
    end else begin
      r_start_q <= start;
      r_stop_q  <= stop;
      r_lap_q   <= lap;
      r_clear_q <= clear;
    end
  end

  assign w_start_evt = start & ~r_start_q;
  assign w_stop_evt  = stop  & ~r_stop_q;
  assign w_lap_evt   = lap   & ~r_lap_q;
  assign w_clear_evt = clear & ~r_clear_q;

  // ---------------------------------------------------------------------------
  // Time base and BCD increment network
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [TICK_W-1:0] r_presc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_lap;
  logic            r_lap_hold;
  logic            r_ovf;
  logic            r_running;

  logic            w_tick;
  logic [N_DIGITS:0] w_carry;
  logic [CW-1:0]   w_count_inc;
  logic            w_all9;
  logic            w_sat;

  assign w_tick = (r_state == ST_RUN) && (r_presc == TICK_LAST);

  // w_carry[i] means digits 0..i-1 are all 9, so digit i rolls on an increment.
  // When every digit is 9 the incremented value is all zeros, which is exactly
  // the wrap value, so the same network serves both overflow modes.
  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      assign w_d              = r_count[4*gi +: 4];
      assign w_carry[gi+1]    = w_carry[gi] & (w_d == 4'd9);
      assign w_count_inc[4*gi +: 4] = w_carry[gi] ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) : w_d;
    end
  endgenerate

  assign w_all9 = w_carry[N_DIGITS];
  // Saturating overflow: counter holds at all 9s and the FSM drops to PAUSE.
  assign w_sat  = w_tick & w_all9 & ~WRAP;

  // ---------------------------------------------------------------------------
  // Control FSM with counter, lap capture and registered status outputs
  // ---------------------------------------------------------------------------
  // IDLE/RUN/PAUSE sequencing; priority is clear > stop > start > lap, with
  // requests that have no meaning in the current state simply ignored.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_count    <= '0;
      r_lap      <= '0;
      r_lap_hold <= 1'b0;
      r_ovf      <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (w_clear_evt) begin
            r_state <= ST_IDLE;
          end else if (w_start_evt) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end

        ST_RUN: begin
          // Prescaler only advances while running.
          if (w_tick) begin
            r_presc <= '0;
          end else begin
            r_presc <= r_presc + 1'b1;
          end

          if (w_tick && (!w_all9 || WRAP)) begin
            r_count <= w_count_inc;
          end
          if (w_tick && w_all9) begin
            r_ovf <= 1'b1;
          end

          if (w_stop_evt || w_sat) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end

          // Lap toggles the freeze; entering the freeze captures the count as
          // it stood before any tick landing in this same cycle.
          if (!w_stop_evt && w_lap_evt) begin
            r_lap_hold <= ~r_lap_hold;
            if (!r_lap_hold) begin
              r_lap <= r_count;
            end
          end
        end

        ST_PAUSE: begin
          if (w_clear_evt) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_lap_hold <= 1'b0;
            r_ovf      <= 1'b0;
            r_presc    <= '0;
          end else if (w_stop_evt) begin
            // Already paused; a stop edge still outranks start and lap.
            r_state <= ST_PAUSE;
          end else if (w_start_evt) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (w_lap_evt) begin
            r_lap_hold <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display register
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_bcd_out;

  // Displayed value follows the lap snapshot while frozen, else the live count.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_out <= '0;
    end else begin
      r_bcd_out <= r_lap_hold ? r_lap : r_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0]   r_scan_div;
  logic [IDX_W-1:0]    r_idx;
  logic [N_DIGITS-1:0] r_an;
  logic [3:0]          r_digit;
  logic                w_scan_step;
  logic [N_DIGITS-1:0] w_an_next;
  logic [3:0]          w_digit [N_DIGITS];

  assign w_scan_step = (r_scan_div == SCAN_LAST);

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_scan
      assign w_an_next[gi] = (r_idx != IDX_W'(gi));
      assign w_digit[gi]   = r_bcd_out[4*gi +: 4];
    end
  endgenerate

  // Free-running scan divider and digit index; runs in every FSM state.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_div <= '0;
      r_idx      <= '0;
    end else if (w_scan_step) begin
      r_scan_div <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_div <= r_scan_div + 1'b1;
    end
  end

  // Anode select and its digit are registered from the same index so they
  // always change on the same edge.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_an    <= AN_RESET;
      r_digit <= 4'd0;
    end else begin
      r_an    <= w_an_next;
      r_digit <= w_digit[r_idx];
    end
  end

  assign bcd_out   = r_bcd_out;
  assign digit_bcd = r_digit;
  assign sseg_an   = r_an;
  assign running   = r_running;
  assign lap_hold  = r_lap_hold;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: a vector table for the main
// start/stop/clear/lap flow, plus hand sequences for async reset, digit scan
// and overflow (on small 2-digit / 1-digit instances that tick every cycle).
module tb_stopwatch_lap_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: CLK_HZ=100, TICK_HZ=10, SCAN_HZ=50, 4 digits, saturating.
  logic        start, stop, lap, clear;
  logic [15:0] bcd_out;
  logic [3:0]  digit_bcd;
  logic [3:0]  sseg_an;
  logic        running, lap_hold, ovf;

  stopwatch_lap_core #(
    .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .N_DIGITS(4), .WRAP(1'b0)
  ) u_dut (
    .clk100MHz(clk), .rst_n(rst_n),
    .start(start), .stop(stop), .lap(lap), .clear(clear),
    .bcd_out(bcd_out), .digit_bcd(digit_bcd), .sseg_an(sseg_an),
    .running(running), .lap_hold(lap_hold), .ovf(ovf)
  );

  // Small instances: one tick per cycle in RUN, to reach all-9s quickly.
  logic       s_start, s_stop, s_lap, s_clear;
  logic [7:0] w0_bcd, w1_bcd;
  logic [3:0] w0_dig, w1_dig, n1_dig;
  logic [1:0] w0_an, w1_an;
  logic       w0_run, w0_hold, w0_ovf, w1_run, w1_hold, w1_ovf;
  logic [3:0] n1_bcd;
  logic [0:0] n1_an;
  logic       n1_run, n1_hold, n1_ovf;

  stopwatch_lap_core #(
    .CLK_HZ(10), .TICK_HZ(10), .SCAN_HZ(10), .N_DIGITS(2), .WRAP(1'b0)
  ) u_sat (
    .clk100MHz(clk), .rst_n(rst_n),
    .start(s_start), .stop(s_stop), .lap(s_lap), .clear(s_clear),
    .bcd_out(w0_bcd), .digit_bcd(w0_dig), .sseg_an(w0_an),
    .running(w0_run), .lap_hold(w0_hold), .ovf(w0_ovf)
  );

  stopwatch_lap_core #(
    .CLK_HZ(10), .TICK_HZ(10), .SCAN_HZ(10), .N_DIGITS(2), .WRAP(1'b1)
  ) u_wrap (
    .clk100MHz(clk), .rst_n(rst_n),
    .start(s_start), .stop(s_stop), .lap(s_lap), .clear(s_clear),
    .bcd_out(w1_bcd), .digit_bcd(w1_dig), .sseg_an(w1_an),
    .running(w1_run), .lap_hold(w1_hold), .ovf(w1_ovf)
  );

  stopwatch_lap_core #(
    .CLK_HZ(10), .TICK_HZ(10), .SCAN_HZ(10), .N_DIGITS(1), .WRAP(1'b1)
  ) u_one (
    .clk100MHz(clk), .rst_n(rst_n),
    .start(s_start), .stop(s_stop), .lap(s_lap), .clear(s_clear),
    .bcd_out(n1_bcd), .digit_bcd(n1_dig), .sseg_an(n1_an),
    .running(n1_run), .lap_hold(n1_hold), .ovf(n1_ovf)
  );

  // Clock edges since the last reset release, used to phase the scan check.
  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st, sp, lp, cl;
    int          wait_n;
    logic [15:0] bcd;
    logic        run, hold, of;
  } vec_t;

  vec_t vecs [18];

  logic [3:0]  an_seq [4];
  logic [15:0] frozen;

  initial begin
    // {start, stop, lap, clear, extra cycles, bcd_out, running, lap_hold, ovf}
    vecs[0]  = '{1,0,0,0,   0, 16'h0000, 1, 0, 0};
    vecs[1]  = '{0,0,0,0, 104, 16'h0010, 1, 0, 0};
    vecs[2]  = '{0,0,0,1, 129, 16'h0023, 1, 0, 0};
    vecs[3]  = '{0,1,0,0,   0, 16'h0023, 0, 0, 0};
    vecs[4]  = '{0,0,0,0, 500, 16'h0023, 0, 0, 0};
    vecs[5]  = '{1,0,0,0,  10, 16'h0024, 1, 0, 0};
    vecs[6]  = '{0,1,0,0,   0, 16'h0024, 0, 0, 0};
    vecs[7]  = '{0,0,0,1,   1, 16'h0000, 0, 0, 0};
    vecs[8]  = '{1,0,0,0,   0, 16'h0000, 1, 0, 0};
    vecs[9]  = '{0,0,0,0,  54, 16'h0005, 1, 0, 0};
    vecs[10] = '{0,0,1,0,  50, 16'h0005, 1, 1, 0};
    vecs[11] = '{0,0,1,0,   1, 16'h0010, 1, 0, 0};
    vecs[12] = '{0,1,0,0,   0, 16'h0010, 0, 0, 0};
    vecs[13] = '{1,1,0,1,   1, 16'h0000, 0, 0, 0};
    vecs[14] = '{1,0,0,0,   0, 16'h0000, 1, 0, 0};
    vecs[15] = '{0,0,1,0,  20, 16'h0000, 1, 1, 0};
    vecs[16] = '{0,1,0,0,   0, 16'h0000, 0, 1, 0};
    vecs[17] = '{0,0,1,0,   1, 16'h0002, 0, 0, 0};

    an_seq[0] = 4'b1110;
    an_seq[1] = 4'b1101;
    an_seq[2] = 4'b1011;
    an_seq[3] = 4'b0111;
    frozen    = 16'h0123;

    rst_n = 1'b0;
    start = 0; stop = 0; lap = 0; clear = 0;
    s_start = 0; s_stop = 0; s_lap = 0; s_clear = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset bcd_out",   bcd_out,   16'h0000);
    chk("reset digit_bcd", digit_bcd, 4'h0);
    chk("reset sseg_an",   sseg_an,   4'b1110);
    chk("reset running",   running,   1'b0);
    chk("reset lap_hold",  lap_hold,  1'b0);
    chk("reset ovf",       ovf,       1'b0);
    $display("reset: bcd=%h an=%b run=%b hold=%b ovf=%b", bcd_out, sseg_an, running, lap_hold, ovf);
    rst_n = 1'b1;

    // Table-driven start/stop/clear/lap flow on the main instance.
    for (int i = 0; i < 18; i++) begin
      start = vecs[i].st; stop = vecs[i].sp; lap = vecs[i].lp; clear = vecs[i].cl;
      @(negedge clk);
      start = 0; stop = 0; lap = 0; clear = 0;
      repeat (vecs[i].wait_n) @(negedge clk);
      chk($sformatf("vec%0d bcd_out", i),  bcd_out,  vecs[i].bcd);
      chk($sformatf("vec%0d running", i),  running,  vecs[i].run);
      chk($sformatf("vec%0d lap_hold", i), lap_hold, vecs[i].hold);
      chk($sformatf("vec%0d ovf", i),      ovf,      vecs[i].of);
      $display("vec %0d: in=%b%b%b%b bcd=%h run=%b hold=%b ovf=%b", i,
               vecs[i].st, vecs[i].sp, vecs[i].lp, vecs[i].cl, bcd_out, running, lap_hold, ovf);
    end

    // Resume from PAUSE, then async reset asserted mid-cycle while running.
    start = 1; @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    chk("resume bcd_out", bcd_out, 16'h0005);
    chk("resume running", running, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst bcd_out",   bcd_out,   16'h0000);
    chk("async rst digit_bcd", digit_bcd, 4'h0);
    chk("async rst sseg_an",   sseg_an,   4'b1110);
    chk("async rst running",   running,   1'b0);
    chk("async rst lap_hold",  lap_hold,  1'b0);
    chk("async rst ovf",       ovf,       1'b0);
    $display("async reset: bcd=%h an=%b run=%b", bcd_out, sseg_an, running);

    // Release and count to 0x0123, freeze it with lap, then watch the scan.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (1233) @(negedge clk);
    lap = 1;
    @(negedge clk);
    lap = 0;
    repeat (4) @(negedge clk);
    chk("freeze bcd_out",  bcd_out,  frozen);
    chk("freeze lap_hold", lap_hold, 1'b1);
    $display("freeze: bcd=%h hold=%b", bcd_out, lap_hold);
    for (int k = 0; k < 16; k++) begin
      int idx;
      logic [3:0] exp_dig;
      @(negedge clk);
      idx     = ((edge_cnt - 1) / 2) % 4;
      exp_dig = frozen[4*idx +: 4];
      chk($sformatf("scan%0d sseg_an", k),   sseg_an,   an_seq[idx]);
      chk($sformatf("scan%0d digit_bcd", k), digit_bcd, exp_dig);
      $display("scan %0d: edge=%0d an=%b digit=%h", k, edge_cnt, sseg_an, digit_bcd);
    end

    // Overflow on the small instances (each counts once per running cycle).
    s_start = 1; @(negedge clk); s_start = 0;
    repeat (99) @(negedge clk);
    chk("pre-ovf sat bcd",   w0_bcd, 8'h98);
    chk("pre-ovf wrap bcd",  w1_bcd, 8'h98);
    chk("pre-ovf sat ovf",   w0_ovf, 1'b0);
    chk("pre-ovf wrap ovf",  w1_ovf, 1'b0);
    chk("pre-ovf sat run",   w0_run, 1'b1);
    chk("one-digit bcd",     n1_bcd, 4'h8);
    chk("one-digit ovf",     n1_ovf, 1'b1);
    chk("one-digit sseg_an", n1_an,  1'b0);
    $display("pre-ovf: sat=%h wrap=%h one=%h", w0_bcd, w1_bcd, n1_bcd);
    @(negedge clk);
    chk("ovf sat run",  w0_run, 1'b0);
    chk("ovf sat ovf",  w0_ovf, 1'b1);
    chk("ovf wrap run", w1_run, 1'b1);
    chk("ovf wrap ovf", w1_ovf, 1'b1);
    $display("ovf: sat run=%b ovf=%b wrap run=%b ovf=%b", w0_run, w0_ovf, w1_run, w1_ovf);
    @(negedge clk);
    chk("ovf sat bcd",  w0_bcd, 8'h99);
    chk("ovf wrap bcd", w1_bcd, 8'h00);
    $display("post-ovf: sat=%h wrap=%h", w0_bcd, w1_bcd);
    s_stop = 1; @(negedge clk); s_stop = 0;
    @(negedge clk);
    chk("stop wrap run",    w1_run, 1'b0);
    chk("stop wrap ovf",    w1_ovf, 1'b1);
    chk("stop wrap bcd",    w1_bcd, 8'h02);
    chk("stop sat bcd",     w0_bcd, 8'h99);
    $display("paused: sat=%h wrap=%h wrap ovf=%b", w0_bcd, w1_bcd, w1_ovf);
    s_start = 1; s_stop = 1; s_clear = 1;
    @(negedge clk);
    s_start = 0; s_stop = 0; s_clear = 0;
    @(negedge clk);
    chk("clear sat bcd",  w0_bcd, 8'h00);
    chk("clear sat ovf",  w0_ovf, 1'b0);
    chk("clear sat run",  w0_run, 1'b0);
    chk("clear wrap bcd", w1_bcd, 8'h00);
    chk("clear wrap ovf", w1_ovf, 1'b0);
    chk("clear one bcd",  n1_bcd, 4'h0);
    $display("cleared: sat=%h/%b wrap=%h/%b one=%h", w0_bcd, w0_ovf, w1_bcd, w1_ovf, n1_bcd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
